// File: rtl/cprv_scoreboard.sv
// Register scoreboard for an in-order issue stage.
// Tracks one pending-write bit per architectural register, detects RAW/WAW
// hazards for the instruction in ID, and keeps a saturating stall-cycle count.
module cprv_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int WB_BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_id_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_en_i,
  input  logic                  ready_ex_i,
  input  logic                  wb_valid_i,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic                  flush_i,
  output logic                  issue_ok_o,
  output logic                  issue_fire_o,
  output logic                  stall_o,
  output logic [ADDR_WIDTH:0]   pending_cnt_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [NREG-1:0]       pend_q;
  logic [NREG-1:0]       pend_d;
  logic [NREG-1:0]       pend_eff;
  logic [NREG-1:0]       wb_mask;
  logic [NREG-1:0]       set_mask;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;
  logic                  hazard;
  logic                  stall_cond;

  // One-hot masks for the writeback clear and the issue-time set.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_valid_i)
      wb_mask[wb_rd_addr_i] = 1'b1;
    if (issue_fire_o && rd_en_i && (rd_addr_i != '0))
      set_mask[rd_addr_i] = 1'b1;
  end

  // Hazard check against pending bits, optionally bypassing this cycle's writeback.
  always_comb begin
    if (WB_BYPASS != 0)
      pend_eff = pend_q & ~wb_mask;
    else
      pend_eff = pend_q;
    hazard = (rs1_used_i & pend_eff[rs1_addr_i]) |
             (rs2_used_i & pend_eff[rs2_addr_i]) |
             (rd_en_i    & pend_eff[rd_addr_i]);
  end

  assign issue_ok_o   = valid_id_i & ~hazard & ~flush_i;
  assign issue_fire_o = issue_ok_o & ready_ex_i;
  assign stall_cond   = valid_id_i & hazard & ~flush_i;

  // Next pending vector: flush beats everything, set beats a same-register clear.
  always_comb begin
    if (flush_i)
      pend_d = '0;
    else
      pend_d = (pend_q & ~wb_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  // Popcount of the next pending vector so the count register tracks pend_q exactly.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREG; i++)
      cnt_d = cnt_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
  end

  // RUN/STALL next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (stall_cond)          state_d = ST_STALL;
      ST_STALL: if (!hazard || flush_i)  state_d = ST_RUN;
      default:                           state_d = ST_RUN;
    endcase
  end

  // Pending bits and their population count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // Saturating hazard-stall cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall_cond && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_o       = (state_q == ST_STALL);
  assign pending_cnt_o = cnt_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_cprv_scoreboard.sv
// Self-checking bench for cprv_scoreboard: a behavioural model pushes expected
// values into a queue as each cycle's stimulus is driven; they are popped and
// compared as the DUT outputs become observable.
module tb_cprv_scoreboard;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_id_i;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i, wb_rd_addr_i;
  logic          rs1_used_i, rs2_used_i, rd_en_i, ready_ex_i, wb_valid_i, flush_i;
  logic          issue_ok_o, issue_fire_o, stall_o;
  logic [AW:0]   pending_cnt_o;
  logic [CW-1:0] stall_cnt_o;

  cprv_scoreboard #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .valid_id_i(valid_id_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .rd_addr_i(rd_addr_i), .rd_en_i(rd_en_i),
    .ready_ex_i(ready_ex_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i),
    .flush_i(flush_i),
    .issue_ok_o(issue_ok_o), .issue_fire_o(issue_fire_o),
    .stall_o(stall_o), .pending_cnt_o(pending_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state.
  bit m_pend[32];
  bit m_stall;
  int m_scnt;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input int unsigned exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input int unsigned got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: got %0d expected a queued value", got);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  function automatic int m_popcnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_pend[i];
    return c;
  endfunction

  function automatic int m_sat_max();
    return (1 << CW) - 1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_stall = 1'b0;
    m_scnt  = 0;
  endtask

  // Registered outputs, expected from the model, compared against the DUT.
  task automatic check_regs();
    push_exp("stall_o", m_stall);
    push_exp("pending_cnt", m_popcnt());
    push_exp("stall_cnt", m_scnt);
    pop_chk(stall_o);
    pop_chk(pending_cnt_o);
    pop_chk(stall_cnt_o);
  endtask

  // One clock cycle: drive inputs just after an edge, check the combinational
  // outputs mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                      input int rd, input bit rden, input bit rdy,
                      input bit wbv, input int wbrd, input bit fl);
    bit eff1, eff2, effd, haz, ok, fire, sc;
    valid_id_i   = v;
    rs1_addr_i   = AW'(r1);
    rs1_used_i   = u1;
    rs2_addr_i   = AW'(r2);
    rs2_used_i   = u2;
    rd_addr_i    = AW'(rd);
    rd_en_i      = rden;
    ready_ex_i   = rdy;
    wb_valid_i   = wbv;
    wb_rd_addr_i = AW'(wbrd);
    flush_i      = fl;

    eff1 = m_pend[r1] && !(wbv && wbrd == r1);
    eff2 = m_pend[r2] && !(wbv && wbrd == r2);
    effd = m_pend[rd] && !(wbv && wbrd == rd);
    haz  = (u1 && eff1) || (u2 && eff2) || (rden && effd);
    ok   = v && !haz && !fl;
    fire = ok && rdy;
    sc   = v && haz && !fl;
    push_exp("issue_ok", ok);
    push_exp("issue_fire", fire);
    #1;
    pop_chk(issue_ok_o);
    pop_chk(issue_fire_o);

    if (fl) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      if (wbv) m_pend[wbrd] = 1'b0;
      if (fire && rden && rd != 0) m_pend[rd] = 1'b1;
    end
    m_stall = m_stall ? (haz && !fl) : sc;
    if (sc && m_scnt < m_sat_max()) m_scnt++;

    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic issue_rd(input int rd);
    step(1, 0, 0, 0, 0, rd, 1, 1, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    valid_id_i = 0; rs1_addr_i = '0; rs2_addr_i = '0; rs1_used_i = 0; rs2_used_i = 0;
    rd_addr_i = '0; rd_en_i = 0; ready_ex_i = 0; wb_valid_i = 0; wb_rd_addr_i = '0; flush_i = 0;
    m_reset();
    #1;
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs();

    // RAW on r5, then bypassed writeback releases it in the same cycle.
    issue_rd(5);
    step(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 1, 1, 5, 0);
    idle();

    // x0 is never marked pending.
    repeat (3) issue_rd(0);
    step(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);

    // Same-cycle writeback and re-issue of r7: set wins.
    issue_rd(7);
    step(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0);

    // Flush clears everything, even with a hazard present.
    issue_rd(3);
    issue_rd(4);
    issue_rd(9);
    step(1, 3, 1, 4, 1, 9, 1, 1, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    idle();

    // EX back-pressure without a hazard neither stalls nor counts.
    step(1, 1, 1, 2, 1, 6, 1, 0, 0, 0, 0);

    // Long RAW hazard drives the stall counter into saturation.
    issue_rd(2);
    repeat (20) step(1, 2, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0, 1, 1, 2, 0);
    idle();

    // Randomised mix over a small register window.
    for (int n = 0; n < 60; n++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 15) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);

    // Asynchronous reset in the middle of a stall with two registers pending.
    issue_rd(6);
    issue_rd(8);
    step(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs();
    step(1, 6, 1, 8, 1, 8, 1, 1, 0, 0, 0);
    step(0, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
